// File: rtl/histogram_equalizer.sv
// Histogram equalizer: accumulates a 64-bin CDF into an 8-bit remap LUT, then streams packed pixels
// through it. Optional macro HIST_CLEAR_EN zeroes each histogram bin right after it is read.
module histogram_equalizer #(
   parameter int BINS       = 64,
   parameter int CNT_W      = 17,
   parameter int ADDR_PIX_W = 14
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     go,
   input  logic [8:0]               dim,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(BINS)-1:0]  addr_hist,
   input  logic [31:0]              datain_hist,
   output logic                     WE_hist,
   output logic [31:0]              dataout_hist,
   output logic [ADDR_PIX_W-1:0]    addr_pix,
   input  logic [31:0]              datain_pix,
   output logic [ADDR_PIX_W-1:0]    addr_eq,
   output logic                     WE_eq,
   output logic [31:0]              dataout_eq,
   output logic [2:0]               dbg_state_o
);

   localparam int BIN_W = $clog2(BINS);
   localparam int DIV_W = CNT_W + 8;
   localparam logic [BIN_W-1:0]    BIN_ONE  = BIN_W'(1);
   localparam logic [BIN_W-1:0]    BIN_LAST = BIN_W'(BINS - 1);
   localparam logic [ADDR_PIX_W:0] W_ONE    = (ADDR_PIX_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HRD   = 3'd1,
      S_HACC  = 3'd2,
      S_HDIV  = 3'd3,
      S_REMAP = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [BIN_W-1:0]      b_q, b_d;
   logic [2:0]            k_q, k_d;
   logic [CNT_W-1:0]      cdf_q, cdf_d;
   logic [DIV_W-1:0]      rem_q, rem_d;
   logic [DIV_W-1:0]      dsh_q, dsh_d;
   logic [6:0]            quo_q, quo_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [ADDR_PIX_W:0]   nw_q, nw_d;
   logic [ADDR_PIX_W-1:0] w_q, w_d;
   logic                  we_q, we_d;
   logic [ADDR_PIX_W-1:0] addr_eq_q, addr_eq_d;

   logic [7:0]            lut_q [BINS];
   logic                  lut_we;
   logic [7:0]            lut_wdata;

   logic [CNT_W-1:0]      dim_ext;
   logic [CNT_W-1:0]      dim_sq;
   logic [CNT_W-1:0]      n_round;
   logic [ADDR_PIX_W:0]   w_total;
   logic [CNT_W-1:0]      cdf_sum;
   logic [DIV_W-1:0]      dividend;
   logic                  div_ge;
   logic [ADDR_PIX_W:0]   w_next;
   logic                  w_last;
   logic                  last_bin;
   logic                  unused_bits;

   assign dim_ext  = CNT_W'(dim);
   assign dim_sq   = dim_ext * dim_ext;
   assign n_round  = dim_sq + CNT_W'(3);
   assign w_total  = n_round[CNT_W-1:2];
   assign cdf_sum  = cdf_q + datain_hist[CNT_W-1:0];
   // cdf*255 as (cdf<<8)-cdf; the widened result cannot wrap for cdf < 2^CNT_W.
   assign dividend = {cdf_sum, 8'd0} - {8'd0, cdf_sum};
   assign div_ge   = (rem_q >= dsh_q);
   assign w_next   = {1'b0, w_q} + W_ONE;
   assign w_last   = (w_next == nw_q);
   assign last_bin = (b_q == BIN_LAST);

   assign unused_bits = ^{datain_hist[31:CNT_W], n_round[1:0], datain_pix[25:24],
                          datain_pix[17:16], datain_pix[9:8], datain_pix[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (go) state_d = (dim == '0) ? S_DONE : S_HRD;
         S_HRD:   state_d = S_HACC;
         S_HACC:  state_d = S_HDIV;
         S_HDIV:  if (k_q == 3'd7) state_d = last_bin ? S_REMAP : S_HRD;
         S_REMAP: if (w_last) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q != S_IDLE) && (state_q != S_DONE);
      done         = (state_q == S_DONE);
      addr_hist    = b_q;
      dataout_hist = '0;
`ifdef HIST_CLEAR_EN
      WE_hist      = (state_q == S_HACC);
`else
      WE_hist      = 1'b0;
`endif
      addr_pix     = w_q;
      addr_eq      = addr_eq_q;
      WE_eq        = we_q;
      dbg_state_o  = state_q;
      dataout_eq   = '0;
      for (int k = 0; k < 4; k++) begin
         dataout_eq[8*k +: 8] = we_q ? lut_q[datain_pix[8*k+2 +: 6]] : 8'd0;
      end
   end

   always_comb begin
      b_d       = b_q;
      k_d       = k_q;
      cdf_d     = cdf_q;
      rem_d     = rem_q;
      dsh_d     = dsh_q;
      quo_d     = quo_q;
      n_d       = n_q;
      nw_d      = nw_q;
      w_d       = w_q;
      we_d      = (state_q == S_REMAP);
      addr_eq_d = addr_eq_q;
      lut_we    = 1'b0;
      lut_wdata = {quo_q, div_ge};
      case (state_q)
         S_IDLE: begin
            if (go && (dim != '0)) begin
               cdf_d = '0;
               b_d   = '0;
               n_d   = dim_sq;
               nw_d  = w_total;
               w_d   = '0;
            end
         end
         S_HRD:  k_d = '0;
         S_HACC: begin
            cdf_d = cdf_sum;
            rem_d = dividend;
            dsh_d = {1'b0, n_q, 7'd0};
         end
         // Restoring division, one quotient bit per cycle; an oversized CDF saturates to 255.
         S_HDIV: begin
            rem_d = div_ge ? (rem_q - dsh_q) : rem_q;
            dsh_d = dsh_q >> 1;
            quo_d = {quo_q[5:0], div_ge};
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) begin
               lut_we = 1'b1;
               b_d    = b_q + BIN_ONE;
            end
         end
         S_REMAP: begin
            addr_eq_d = w_q;
            if (!w_last) w_d = w_next[ADDR_PIX_W-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q       <= '0;
         k_q       <= '0;
         cdf_q     <= '0;
         rem_q     <= '0;
         dsh_q     <= '0;
         quo_q     <= '0;
         n_q       <= '0;
         nw_q      <= '0;
         w_q       <= '0;
         we_q      <= 1'b0;
         addr_eq_q <= '0;
      end else begin
         b_q       <= b_d;
         k_q       <= k_d;
         cdf_q     <= cdf_d;
         rem_q     <= rem_d;
         dsh_q     <= dsh_d;
         quo_q     <= quo_d;
         n_q       <= n_d;
         nw_q      <= nw_d;
         w_q       <= w_d;
         we_q      <= we_d;
         addr_eq_q <= addr_eq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lut_we) lut_q[b_q] <= lut_wdata;
   end

endmodule

// File: tb/tb_histogram_equalizer.sv
// Bench for histogram_equalizer: memory models, CDF/LUT reference model, per-cycle compare process.
// Build with +define+HIST_CLEAR_EN to exercise the bin-clearing variant.
module tb_histogram_equalizer;

   localparam int BINS = 64;
`ifdef HIST_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        go    = 1'b0;
   logic [8:0]  dim   = '0;
   logic        busy, done, WE_hist, WE_eq;
   logic [5:0]  addr_hist;
   logic [31:0] datain_hist = '0;
   logic [31:0] dataout_hist;
   logic [13:0] addr_pix, addr_eq;
   logic [31:0] datain_pix = '0;
   logic [31:0] dataout_eq;
   logic [2:0]  dbg_state;

   logic [31:0] hist_mem  [BINS];
   logic [31:0] hist_save [BINS];
   logic [31:0] pix_mem   [16384];
   logic [31:0] eq_mem    [16384];
   logic [31:0] exp_eq    [16384];
   logic [31:0] eq_snap   [64];
   logic [7:0]  lut_m     [BINS];
   logic [45:0] exp_q [$];
   logic [45:0] ent;
   logic [33:0] addr_save;
   logic [31:0] tmp_w;
   bit          we_h, we_e;
   bit          run_on = 1'b0;
   int          checks = 0, errors = 0;
   int          cyc = 0, exp_dim = 0, exp_w = 0, exp_done = 0;

   histogram_equalizer dut (
      .clk(clk), .rst_n(rst_n), .go(go), .dim(dim), .busy(busy), .done(done),
      .addr_hist(addr_hist), .datain_hist(datain_hist), .WE_hist(WE_hist),
      .dataout_hist(dataout_hist), .addr_pix(addr_pix), .datain_pix(datain_pix),
      .addr_eq(addr_eq), .WE_eq(WE_eq), .dataout_eq(dataout_eq), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous RAMs with one-cycle read latency.
   always @(posedge clk) begin
      datain_hist <= hist_mem[addr_hist];
      datain_pix  <= pix_mem[addr_pix];
      if (WE_hist) hist_mem[addr_hist] = dataout_hist;
      if (WE_eq)   eq_mem[addr_eq]     = dataout_eq;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_on) begin
         cyc = cyc + 1;
         check("busy", 64'(busy), 64'(exp_dim != 0 && cyc <= 641 + exp_w));
         check("done", 64'(done), 64'(cyc == exp_done));
         we_h = CLR && exp_dim != 0 && cyc <= 640 && (cyc % 10) == 2;
         check("we_hist", 64'(WE_hist), 64'(we_h));
         if (we_h) check("clear_addr", 64'(addr_hist), 64'((cyc - 2) / 10));
         if (exp_dim != 0 && cyc >= 641 && cyc <= 640 + exp_w)
            check("addr_pix", 64'(addr_pix), 64'(cyc - 641));
         we_e = exp_dim != 0 && cyc >= 642 && cyc <= 641 + exp_w;
         check("we_eq", 64'(WE_eq), 64'(we_e));
         if (we_e && WE_eq) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL eq_queue: write at cycle %0d with no expected entry", cyc);
            end else begin
               ent = exp_q.pop_front();
               check("eq_write", 64'({addr_eq, dataout_eq}), 64'(ent));
            end
         end
         if (exp_dim == 0) check("addr_hold", 64'({addr_hist, addr_pix, addr_eq}), 64'(addr_save));
      end
   end

   task automatic run_case(input int d, input bit glitch, input int abort_at);
      int     n, wn;
      longint cdf, q;
      logic [31:0] pw, ew;
      bit     aborted;
      n = d * d;
      wn = (n + 3) / 4;
      aborted = 1'b0;
      exp_q.delete();
      cdf = 0;
      for (int b = 0; b < BINS; b++) begin
         cdf = cdf + longint'(hist_mem[b][16:0]);
         q = (n == 0) ? 0 : (cdf * 255) / n;
         if (q > 255) q = 255;
         lut_m[b] = 8'(q);
         hist_save[b] = hist_mem[b];
      end
      for (int w = 0; w < wn; w++) begin
         pw = pix_mem[w];
         for (int k = 0; k < 4; k++) ew[8*k +: 8] = lut_m[pw[8*k+2 +: 6]];
         exp_eq[w] = ew;
         exp_q.push_back({14'(w), ew});
      end
      exp_dim   = d;
      exp_w     = wn;
      exp_done  = (d == 0) ? 1 : 642 + wn;
      addr_save = {addr_hist, addr_pix, addr_eq};
      @(negedge clk);
      dim = 9'(d);
      go  = 1'b1;
      @(posedge clk);
      #1;
      go     = 1'b0;
      cyc    = 0;
      run_on = 1'b1;
      for (int c = 0; c < exp_done + 3 && !aborted; c++) begin
         @(negedge clk);
         #1;
         go = glitch && (cyc == 100 || cyc == 660);
         if (abort_at != 0 && cyc == abort_at) begin
            run_on  = 1'b0;
            rst_n   = 1'b0;
            aborted = 1'b1;
         end
      end
      run_on = 1'b0;
      go     = 1'b0;
      if (aborted) begin
         @(negedge clk);
         check("abort_ctrl", 64'({busy, done, WE_hist, WE_eq, dbg_state, addr_hist, addr_pix, addr_eq}), 64'(0));
         check("abort_data", 64'({dataout_hist, dataout_eq}), 64'(0));
         #1 rst_n = 1'b1;
         exp_q.delete();
         repeat (2) @(negedge clk);
      end else begin
         check("queue_drained", 64'(exp_q.size()), 64'(0));
         for (int w = 0; w < wn; w++) check("eq_mem", 64'(eq_mem[w]), 64'(exp_eq[w]));
         for (int b = 0; b < BINS; b++)
            check("hist_after", 64'(hist_mem[b]), 64'((CLR && d != 0) ? 32'd0 : hist_save[b]));
      end
   endtask

   task automatic load_hist(input int v);
      for (int b = 0; b < BINS; b++) hist_mem[b] = 32'(v);
   endtask

   task automatic fill_eq();
      for (int w = 0; w < 256; w++) eq_mem[w] = 32'hDEAD_BEEF;
   endtask

   task automatic ramp_pix();
      for (int w = 0; w < 64; w++)
         pix_mem[w] = {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
   endtask

   initial begin
      load_hist(0);
      for (int w = 0; w < 256; w++) pix_mem[w] = 32'd0;
      fill_eq();
      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({busy, done, WE_hist, WE_eq, dbg_state, addr_hist, addr_pix, addr_eq}), 64'(0));
      check("reset_data", 64'({dataout_hist, dataout_eq}), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // dim=2, all mass in bin 0: every LUT entry saturates to 255.
      hist_mem[0] = 32'd4;
      pix_mem[0]  = 32'h0302_0100;
      run_case(2, 1'b0, 0);
      check("t1_lut0", 64'(lut_m[0]), 64'(255));
      check("t1_eq0", 64'(eq_mem[0]), 64'h0000_0000_FFFF_FFFF);

      // dim=16, flat histogram of 4 per bin over a full 0..255 pixel ramp.
      load_hist(4);
      ramp_pix();
      fill_eq();
      run_case(16, 1'b0, 0);
      check("t2_lut0", 64'(lut_m[0]), 64'(3));
      check("t2_lut32", 64'(lut_m[32]), 64'(131));
      check("t2_lut63", 64'(lut_m[63]), 64'(255));
      check("t2_eq0", 64'(eq_mem[0]), 64'h0303_0303);
      check("t2_eq32", 64'(eq_mem[32]), 64'h8383_8383);
      check("t2_eq63", 64'(eq_mem[63]), 64'hFFFF_FFFF);
      for (int w = 0; w < 64; w++) eq_snap[w] = eq_mem[w];

      // go pulses during the CDF phase and during REMAP must be ignored.
      load_hist(4);
      fill_eq();
      run_case(16, 1'b1, 0);

      // Reset in the middle of REMAP, then a clean rerun must reproduce the first result.
      load_hist(4);
      fill_eq();
      run_case(16, 1'b0, 670);
      load_hist(4);
      fill_eq();
      run_case(16, 1'b0, 0);
      for (int w = 0; w < 64; w++) check("rerun_eq", 64'(eq_mem[w]), 64'(eq_snap[w]));

      // Odd dim: 25 pixels in 7 words, pad bytes of the last word remapped too.
      load_hist(0);
      hist_mem[0] = 32'd5; hist_mem[10] = 32'd5; hist_mem[20] = 32'd5;
      hist_mem[40] = 32'd5; hist_mem[63] = 32'd5;
      for (int w = 0; w < 7; w++) begin
         for (int k = 0; k < 4; k++) tmp_w[8*k +: 8] = 8'(w*37 + k*53 + 11);
         pix_mem[w] = tmp_w;
      end
      fill_eq();
      run_case(5, 1'b0, 0);
      check("t_odd_lut10", 64'(lut_m[10]), 64'(102));

      // Histogram sum exceeds N: quotient clipped at 255.
      load_hist(0);
      hist_mem[0] = 32'd2;
      hist_mem[1] = 32'd6;
      pix_mem[0]  = 32'h0704_0300;
      fill_eq();
      run_case(2, 1'b0, 0);
      check("clip_lut0", 64'(lut_m[0]), 64'(127));
      check("clip_lut1", 64'(lut_m[1]), 64'(255));
      check("clip_eq0", 64'(eq_mem[0]), 64'hFFFF_7F7F);

      // dim=0: immediate done, no memory activity.
      load_hist(7);
      fill_eq();
      run_case(0, 1'b0, 0);
      check("dim0_eq_untouched", 64'(eq_mem[0]), 64'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
